// File: rtl/sntrup_pkg.sv
// Shared constants, FSM state type and term-mask helper for the Rq fold stage.
package sntrup_pkg;

  localparam int P         = 761;
  localparam int Q         = 4591;
  localparam int CW_IN     = 26;
  localparam int CW_OUT    = 13;
  localparam int AW        = 11;
  localparam int ACC_W     = CW_IN + 2;
  localparam int Q_HALF    = (Q - 1) / 2;

  // Barrett reduction: quotient estimate = (x * floor(2^K / Q)) >> K
  localparam int BARRETT_K  = 32;
  localparam int BARRETT_MW = 20;
  localparam logic [BARRETT_MW-1:0] BARRETT_M =
    BARRETT_MW'((64'd1 << BARRETT_K) / 64'(Q));

  // Address-width views of the fold constants
  localparam logic [AW-1:0] P_AW    = AW'(P);
  localparam logic [AW-1:0] P_M1_AW = AW'(P - 1);
  localparam logic [AW-1:0] P_M2_AW = AW'(P - 2);
  localparam logic [AW-1:0] MAX_IDX = AW'(2 * P - 2);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S_A  = 3'd1,
    S_B  = 3'd2,
    S_C  = 3'd3,
    S_D  = 3'd4,
    S_W  = 3'd5,
    FIN  = 3'd6
  } state_e;

  // A product coefficient contributes only if its index is within the captured degree
  function automatic logic [ACC_W-1:0] masked_term(input logic [CW_IN-1:0] data,
                                                   input logic [AW-1:0]    idx,
                                                   input logic [AW-1:0]    deg);
    logic [ACC_W-1:0] t;
    if (idx <= deg) begin
      t = {2'b00, data};
    end else begin
      t = '0;
    end
    return t;
  endfunction

endpackage

// File: rtl/polyn_fold_rq_if.sv
// Bus between the fold stage, its controller and the source/result memories.
interface polyn_fold_rq_if;
  import sntrup_pkg::*;

  logic              start;
  logic [AW-1:0]     deg_in;
  logic [AW-1:0]     rd_addr;
  logic [CW_IN-1:0]  rd_data;
  logic [AW-1:0]     wr_addr;
  logic [CW_OUT-1:0] wr_data;
  logic              wr_en;
  logic [AW-1:0]     deg_out;
  logic              busy;
  logic              done;

  modport master (
    output start, deg_in, rd_data,
    input  rd_addr, wr_addr, wr_data, wr_en, deg_out, busy, done
  );

  modport slave (
    input  start, deg_in, rd_data,
    output rd_addr, wr_addr, wr_data, wr_en, deg_out, busy, done
  );
endinterface

// File: rtl/mod_q_reduce.sv
// Combinational reduction of a (CW_IN+2)-bit accumulator modulo Q.
// Build option FOLD_CENTERED_EN: output the centered representative in
// [-(Q-1)/2, (Q-1)/2] as two's complement instead of [0, Q-1].
module mod_q_reduce
  import sntrup_pkg::*;
(
  input  logic [ACC_W-1:0]  val_i,
  output logic [CW_OUT-1:0] res_o
);

  localparam int PW = ACC_W + BARRETT_MW;

  logic [PW-1:0]     prod_s;
  logic [ACC_W-1:0]  quot_s;
  logic [ACC_W-1:0]  rem_s;
  logic [ACC_W-1:0]  rem1_s;
  logic [ACC_W-1:0]  rem2_s;
  logic [CW_OUT-1:0] red_s;

  // Barrett estimate undershoots the true quotient by at most two, so two
  // conditional subtractions bring the remainder into [0, Q-1]
  always_comb begin
    prod_s = PW'(val_i) * PW'(BARRETT_M);
    quot_s = ACC_W'(prod_s >> BARRETT_K);
    rem_s  = val_i - (quot_s * ACC_W'(Q));
    if (rem_s >= ACC_W'(Q)) begin
      rem1_s = rem_s - ACC_W'(Q);
    end else begin
      rem1_s = rem_s;
    end
    if (rem1_s >= ACC_W'(Q)) begin
      rem2_s = rem1_s - ACC_W'(Q);
    end else begin
      rem2_s = rem1_s;
    end
    red_s = CW_OUT'(rem2_s);
`ifdef FOLD_CENTERED_EN
    if (red_s > CW_OUT'(Q_HALF)) begin
      res_o = red_s - CW_OUT'(Q);
    end else begin
      res_o = red_s;
    end
`else
    res_o = red_s;
`endif
  end

endmodule

// File: rtl/polyn_fold_rq.sv
// Rq fold stage: reads a raw product c[0..deg_in], folds it modulo
// x^P - x - 1, reduces each coefficient modulo Q and writes P results.
// Build option FOLD_CENTERED_EN selects centered output coefficients.
module polyn_fold_rq
  import sntrup_pkg::*;
(
  input logic            clk,
  input logic            rst,
  polyn_fold_rq_if.slave bus
);

  state_e            state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [AW-1:0]     deg_q, deg_d;
  logic [AW-1:0]     deg_out_q, deg_out_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [AW-1:0]     rd_addr_q, rd_addr_d;
  logic [AW-1:0]     wr_addr_q, wr_addr_d;
  logic              wr_en_q, wr_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [CW_OUT-1:0] wr_data_s;

  mod_q_reduce u_reduce (
    .val_i (acc_q),
    .res_o (wr_data_s)
  );

  // Next-state, accumulation and registered-output decode
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    deg_d     = deg_q;
    deg_out_d = deg_out_q;
    acc_d     = acc_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = S_A;
          idx_d   = '0;
          // Degrees beyond 2P-2 have no meaning for the fold; clamp them
          if (bus.deg_in > MAX_IDX) begin
            deg_d = MAX_IDX;
          end else begin
            deg_d = bus.deg_in;
          end
          if (bus.deg_in < P_AW) begin
            deg_out_d = bus.deg_in;
          end else begin
            deg_out_d = P_M1_AW;
          end
        end else begin
          state_d = IDLE;
        end
      end
      S_A: state_d = S_B;
      S_B: begin
        state_d = S_C;
        acc_d   = masked_term(bus.rd_data, idx_q, deg_q);
      end
      S_C: begin
        state_d = S_D;
        acc_d   = acc_q + masked_term(bus.rd_data, idx_q + P_AW, deg_q);
      end
      S_D: begin
        state_d = S_W;
        // c[i+P-1] folds onto x^i only for i >= 1
        if (idx_q != '0) begin
          acc_d = acc_q + masked_term(bus.rd_data, idx_q + P_M1_AW, deg_q);
        end else begin
          acc_d = acc_q;
        end
      end
      S_W: begin
        if (idx_q == P_M1_AW) begin
          state_d = FIN;
        end else begin
          state_d = S_A;
          idx_d   = idx_q + 11'd1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Read address for the state being entered; the memory answers one cycle later
    case (state_d)
      S_A: rd_addr_d = idx_d;
      S_B: begin
        // i+P exceeds 2P-2 only for i=P-1, where that term is masked anyway
        if (idx_d > P_M2_AW) begin
          rd_addr_d = MAX_IDX;
        end else begin
          rd_addr_d = idx_d + P_AW;
        end
      end
      S_C:     rd_addr_d = idx_d + P_M1_AW;
      default: rd_addr_d = rd_addr_q;
    endcase

    wr_en_d = (state_d == S_W);
    if (state_d == S_W) begin
      wr_addr_d = idx_d;
    end else begin
      wr_addr_d = wr_addr_q;
    end
    busy_d = (state_d == S_A) || (state_d == S_B) || (state_d == S_C) ||
             (state_d == S_D) || (state_d == S_W);
    done_d = (state_d == FIN);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      deg_q     <= '0;
      deg_out_q <= '0;
      acc_q     <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      deg_q     <= deg_d;
      deg_out_q <= deg_out_d;
      acc_q     <= acc_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_en_q   <= wr_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.rd_addr = rd_addr_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_s;
  assign bus.wr_en   = wr_en_q;
  assign bus.deg_out = deg_out_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule
